priority_grant_arbiter: RTL and testbench

Sequential 8-requester arbiter that shares one downstream resource (bus slot, shared datapath) among requesters. It uses the team's 8-to-3 priority encoder as its selection core, with index 0 as the highest priority. A grant is held until the requester releases it or a hold timeout forces it off. A timed-out requester is masked until it drops its request, so one requester cannot starve the rest.

---
 rtl/priority_grant_arbiter_pkg.sv | 13 +
 rtl/Binary_Priority_Encoder.sv | 25 ++
 rtl/priority_grant_arbiter.sv | 106 ++++++++++
 tb/tb_priority_grant_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/priority_grant_arbiter_pkg.sv
// Shared constants and state encoding for the priority grant arbiter.
package priority_grant_arbiter_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned ID_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/Binary_Priority_Encoder.sv
// 8-to-3 priority encoder: lowest set index wins; done flags any set input while enabled.
module Binary_Priority_Encoder
  import priority_grant_arbiter_pkg::*;
(
  input  logic                 en,
  input  logic [0:NUM_REQ-1]   I,
  output logic [ID_W-1:0]      Y,
  output logic                 done
);

  always_comb begin
    Y    = '0;
    done = 1'b0;
    if (en) begin
      // Walk from the lowest priority up so the lowest index is written last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (I[i]) begin
          Y    = ID_W'(i);
          done = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/priority_grant_arbiter.sv
// Fixed-priority 8-requester arbiter with grant hold, hold timeout and timed-out requester masking.
module priority_grant_arbiter
  import priority_grant_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [0:NUM_REQ-1] req,
  output logic [0:NUM_REQ-1] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam int unsigned CntW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CntW-1:0] HoldLast = (HOLD_MAX == 0) ? '0 : CntW'(HOLD_MAX - 1);

  arb_state_e          state_q, state_d;
  logic [0:NUM_REQ-1]  gnt_q, gnt_d;
  logic [0:NUM_REQ-1]  mask_q, mask_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CntW-1:0]     hold_cnt_q, hold_cnt_d;
  logic                timeout_q, timeout_d;

  logic [0:NUM_REQ-1]  elig;
  logic [ID_W-1:0]     next_id;
  logic                any_elig;

  assign elig = req & ~mask_q;

  Binary_Priority_Encoder u_enc (
    .en   (en),
    .I    (elig),
    .Y    (next_id),
    .done (any_elig)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    id_d       = id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    // A mask bit lasts only while its requester keeps requesting.
    mask_d     = mask_q & req;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (en && any_elig) begin
          id_d          = next_id;
          gnt_d[next_id] = 1'b1;
          hold_cnt_d    = '0;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (!req[id_q]) begin
          gnt_d   = '0;
          state_d = GAP;
        end else if ((HOLD_MAX != 0) && (hold_cnt_q == HoldLast)) begin
          gnt_d        = '0;
          mask_d[id_q] = 1'b1;
          timeout_d    = 1'b1;
          state_d      = GAP;
        end else if (HOLD_MAX != 0) begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      GAP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      mask_q     <= '0;
      id_q       <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      mask_q     <= mask_d;
      id_q       <= id_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_priority_grant_arbiter.sv
// Self-checking bench: per-cycle vector table through a scoreboard, plus async-reset and no-timeout runs.
module tb_priority_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [0:7] req;
  logic [0:7] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  logic [0:7] req_z;
  logic [0:7] gnt_z;
  logic [2:0] gnt_id_z;
  logic       gnt_valid_z;
  logic       timeout_z;

  int total = 0;
  int bad   = 0;

  priority_grant_arbiter #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  priority_grant_arbiter #(.HOLD_MAX(0)) dut_z (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req_z),
    .gnt       (gnt_z),
    .gnt_id    (gnt_id_z),
    .gnt_valid (gnt_valid_z),
    .timeout   (timeout_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [0:7] req;
    logic [0:7] gnt;
    logic [2:0] id;
    logic       to;
  } vec_t;

  typedef struct {
    logic [0:7] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic logic [0:7] oh(input int k);
    logic [0:7] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic add(input logic r, input logic e, input logic [0:7] rq,
                     input logic [0:7] g, input logic [2:0] id, input logic to);
    vec_t v;
    v.rst_n = r;
    v.en    = e;
    v.req   = rq;
    v.gnt   = g;
    v.id    = id;
    v.to    = to;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %b, wanted %b at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard: got empty queue, wanted one entry", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " gnt"},       gnt,                   e.gnt);
    check({tag, " gnt_id"},    {5'b0, gnt_id},        {5'b0, e.id});
    check({tag, " gnt_valid"}, {7'b0, gnt_valid},     {7'b0, e.valid});
    check({tag, " timeout"},   {7'b0, timeout},       {7'b0, e.to});
  endtask

  // Drive one vector before a rising edge, then compare just after it.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n   = v.rst_n;
    en      = v.en;
    req     = v.req;
    e.gnt   = v.gnt;
    e.id    = v.id;
    e.valid = (v.gnt != 8'h00);
    e.to    = v.to;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, wanted finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    req_z = 8'h00;

    // Reset, first grant, release.
    add(0, 1, 8'hFF, 8'h00, 0, 0);
    add(0, 1, 8'hFF, 8'h00, 0, 0);
    add(1, 1, 8'hFF, oh(0), 0, 0);
    add(1, 1, 8'h00, 8'h00, 0, 0);
    add(1, 1, 8'h00, 8'h00, 0, 0);
    // Priority: 2 beats 5, then 5 after two empty cycles.
    add(1, 1, oh(2) | oh(5), oh(2), 2, 0);
    add(1, 1, oh(2) | oh(5), oh(2), 2, 0);
    add(1, 1, oh(5), 8'h00, 2, 0);
    add(1, 1, oh(5), 8'h00, 2, 0);
    add(1, 1, oh(5), oh(5), 5, 0);
    add(1, 1, 8'h00, 8'h00, 5, 0);
    add(1, 1, 8'h00, 8'h00, 5, 0);
    // Timeout of 3 after four cycles, 6 takes over, 3 stays masked.
    add(1, 1, oh(3) | oh(6), oh(3), 3, 0);
    add(1, 1, oh(3) | oh(6), oh(3), 3, 0);
    add(1, 1, oh(3) | oh(6), oh(3), 3, 0);
    add(1, 1, oh(3) | oh(6), oh(3), 3, 0);
    add(1, 1, oh(3) | oh(6), 8'h00, 3, 1);
    add(1, 1, oh(3) | oh(6), 8'h00, 3, 0);
    add(1, 1, oh(3) | oh(6), oh(6), 6, 0);
    add(1, 1, oh(3), 8'h00, 6, 0);
    add(1, 1, oh(3), 8'h00, 6, 0);
    add(1, 1, oh(3), 8'h00, 6, 0);
    add(1, 1, 8'h00, 8'h00, 6, 0);
    add(1, 1, oh(3), oh(3), 3, 0);
    add(1, 1, 8'h00, 8'h00, 3, 0);
    add(1, 1, 8'h00, 8'h00, 3, 0);
    // Enable dropped mid-grant keeps the grant, blocks the next one.
    add(1, 1, oh(1), oh(1), 1, 0);
    add(1, 0, oh(1), oh(1), 1, 0);
    add(1, 0, oh(1) | oh(4), oh(1), 1, 0);
    add(1, 0, oh(4), 8'h00, 1, 0);
    add(1, 0, oh(4), 8'h00, 1, 0);
    add(1, 0, oh(4), 8'h00, 1, 0);
    add(1, 0, oh(4), 8'h00, 1, 0);
    add(1, 1, oh(4), oh(4), 4, 0);
    add(1, 1, 8'h00, 8'h00, 4, 0);
    add(1, 1, 8'h00, 8'h00, 4, 0);
    // Mask 6 by timeout, then grant 7.
    add(1, 1, oh(6) | oh(7), oh(6), 6, 0);
    add(1, 1, oh(6) | oh(7), oh(6), 6, 0);
    add(1, 1, oh(6) | oh(7), oh(6), 6, 0);
    add(1, 1, oh(6) | oh(7), oh(6), 6, 0);
    add(1, 1, oh(6) | oh(7), 8'h00, 6, 1);
    add(1, 1, oh(6) | oh(7), 8'h00, 6, 0);
    add(1, 1, oh(6) | oh(7), oh(7), 7, 0);
    add(1, 1, oh(6) | oh(7), oh(7), 7, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Async reset between edges while 7 holds the grant.
    #2;
    rst_n = 1'b0;
    #1;
    check("async gnt",       gnt,              8'h00);
    check("async gnt_valid", {7'b0, gnt_valid}, 8'h00);
    check("async timeout",   {7'b0, timeout},   8'h00);
    check("async gnt_id",    {5'b0, gnt_id},    8'h00);

    // Reset also cleared mask[6], so 6 wins again instead of 7.
    begin
      vec_t v;
      v.rst_n = 1; v.en = 1; v.req = oh(6) | oh(7); v.gnt = oh(6); v.id = 6; v.to = 0;
      apply(v, "post_reset");
    end

    // No-timeout instance: a held request keeps its grant indefinitely.
    @(negedge clk);
    req   = 8'h00;
    req_z = oh(0);
    @(posedge clk);
    #1;
    check("hold0 first gnt", gnt_z, oh(0));
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold0 gnt c%0d", c),     gnt_z,               oh(0));
      check($sformatf("hold0 timeout c%0d", c), {7'b0, timeout_z},   8'h00);
    end
    check("hold0 gnt_id", {5'b0, gnt_id_z}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
